// File: rtl/rx_unit.sv
// Oversampling UART receiver: 2-flop synchronized rxd, start/data/stop FSM, sticky status flags.
// Optional even-parity bit enabled by defining RX_PARITY_EN.
module rx_unit #(
    parameter int OVS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       en_rx,
    input  logic       rd,
    output logic [7:0] d_out,
    output logic       rs,
    output logic       fe,
    output logic       oe,
    output logic       pe
);

    localparam int CW = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      nbit_q, nbit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      dout_q, dout_d;
    logic            rs_q, rs_d;
    logic            fe_q, fe_d;
    logic            oe_q, oe_d;
    logic            pe_q, pe_d;
    logic            rxd_m_q, rxd_m_d;
    logic            rxd_s_q, rxd_s_d;
    logic            prev_q, prev_d;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        nbit_d  = nbit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        rs_d    = rs_q;
        fe_d    = fe_q;
        oe_d    = oe_q;
        pe_d    = pe_q;
        rxd_m_d = rxd;
        rxd_s_d = rxd_m_q;
        prev_d  = prev_q;

        if (rd) begin
            rs_d = 1'b0;
            fe_d = 1'b0;
            oe_d = 1'b0;
            pe_d = 1'b0;
        end

        if (en_rx) begin
            // prev tracks the line on every tick, so a held-low break never looks like a new falling edge
            prev_d = rxd_s_q;
            case (state_q)
                IDLE: begin
                    if (!rxd_s_q && prev_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d   = '0;
                        nbit_d  = '0;
                        state_d = rxd_s_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        shift_d = {rxd_s_q, shift_q[7:1]};
                        nbit_d  = nbit_q + 3'd1;
                        if (nbit_q == 3'd7) begin
`ifdef RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PARITY: begin
`ifdef RX_PARITY_EN
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        pe_d    = (^shift_q) ^ rxd_s_q;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    state_d = IDLE;
`endif
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        dout_d  = shift_q;
                        rs_d    = 1'b1;
                        fe_d    = ~rxd_s_q;
                        oe_d    = rd ? 1'b0 : (oe_q | rs_q);
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only; all decisions live in the always_comb above.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nbit_q  <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            rs_q    <= 1'b0;
            fe_q    <= 1'b0;
            oe_q    <= 1'b0;
            pe_q    <= 1'b0;
            rxd_m_q <= 1'b1;
            rxd_s_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nbit_q  <= nbit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            rs_q    <= rs_d;
            fe_q    <= fe_d;
            oe_q    <= oe_d;
            pe_q    <= pe_d;
            rxd_m_q <= rxd_m_d;
            rxd_s_q <= rxd_s_d;
            prev_q  <= prev_d;
        end
    end

    assign d_out = dout_q;
    assign rs    = rs_q;
    assign fe    = fe_q;
    assign oe    = oe_q;
`ifdef RX_PARITY_EN
    assign pe    = pe_q;
`else
    assign pe    = 1'b0;
`endif

endmodule

// File: tb/tb_rx_unit.sv
// Directed bench for rx_unit (OVS=16): reset, 8N1 reception, glitch, break, overrun, mid-frame reset, tick gating.
// Parity scenarios run when RX_PARITY_EN is defined.
module tb_rx_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       en_rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] d_out;
    logic       rs, fe, oe, pe;

    int  passed = 0;
    int  total  = 0;
    bit  gate   = 1'b0;
    int  rs_rise = 0;
    logic rs_prev = 1'b0;

    rx_unit #(.OVS(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .en_rx (en_rx),
        .rd    (rd),
        .d_out (d_out),
        .rs    (rs),
        .fe    (fe),
        .oe    (oe),
        .pe    (pe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rs_prev <= rs;
        if (rs && !rs_prev) rs_rise <= rs_rise + 1;
    end

    // Advance one clock and settle 1 ns past the edge; in gated mode en_rx toggles every clock.
    task automatic tick();
        @(posedge clk);
        #1;
        if (gate) en_rx = ~en_rx;
    endtask

    task automatic send_bit(input logic b, input int n);
        rxd = b;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_b, input int n);
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(d[i], n);
`ifdef RX_PARITY_EN
        send_bit(par, n);
`else
        if (par === 1'bx) send_bit(1'b1, 0);
`endif
        send_bit(stop_b, n);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        cmp("reset d_out", d_out, 8'h00);
        cmp("reset rs", {7'd0, rs}, 8'd0);
        cmp("reset fe", {7'd0, fe}, 8'd0);
        cmp("reset oe", {7'd0, oe}, 8'd0);
        cmp("reset pe", {7'd0, pe}, 8'd0);
    endtask

    task automatic test_basic();
        send_bit(1'b1, 20);
        send_frame(8'hA5, ^8'hA5, 1'b1, 16);
        send_bit(1'b1, 4);
        cmp("basic d_out", d_out, 8'hA5);
        cmp("basic rs", {7'd0, rs}, 8'd1);
        cmp("basic fe", {7'd0, fe}, 8'd0);
        cmp("basic oe", {7'd0, oe}, 8'd0);
        pulse_rd();
        cmp("basic rs after rd", {7'd0, rs}, 8'd0);
    endtask

    task automatic test_glitch();
        send_bit(1'b0, 4);
        send_bit(1'b1, 40);
        cmp("glitch rs", {7'd0, rs}, 8'd0);
        cmp("glitch fe", {7'd0, fe}, 8'd0);
        cmp("glitch d_out", d_out, 8'hA5);
        send_frame(8'h96, ^8'h96, 1'b1, 16);
        send_bit(1'b1, 4);
        cmp("post-glitch d_out", d_out, 8'h96);
        pulse_rd();
    endtask

    task automatic test_break();
        int r0;
        r0 = rs_rise;
        send_frame(8'h3C, ^8'h3C, 1'b0, 16);
        send_bit(1'b0, 40 * 16);
        cmp("break d_out", d_out, 8'h3C);
        cmp("break rs", {7'd0, rs}, 8'd1);
        cmp("break fe", {7'd0, fe}, 8'd1);
        cmp("break oe", {7'd0, oe}, 8'd0);
        cmp("break completions", 8'(rs_rise - r0), 8'd1);
        send_bit(1'b1, 32);
        cmp("break completions after release", 8'(rs_rise - r0), 8'd1);
        pulse_rd();
        cmp("break fe after rd", {7'd0, fe}, 8'd0);
        cmp("break rs after rd", {7'd0, rs}, 8'd0);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, ^8'h11, 1'b1, 16);
        send_bit(1'b1, 16);
        cmp("overrun first d_out", d_out, 8'h11);
        cmp("overrun first oe", {7'd0, oe}, 8'd0);
        send_frame(8'h22, ^8'h22, 1'b1, 16);
        send_bit(1'b1, 4);
        cmp("overrun d_out", d_out, 8'h22);
        cmp("overrun rs", {7'd0, rs}, 8'd1);
        cmp("overrun oe", {7'd0, oe}, 8'd1);
        cmp("overrun fe", {7'd0, fe}, 8'd0);
        pulse_rd();
        cmp("overrun rs after rd", {7'd0, rs}, 8'd0);
        cmp("overrun oe after rd", {7'd0, oe}, 8'd0);
    endtask

    task automatic test_rst_mid_frame();
        send_bit(1'b0, 16);
        send_bit(1'b1, 16 * 4 + 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("midrst d_out", d_out, 8'h00);
        cmp("midrst rs", {7'd0, rs}, 8'd0);
        send_bit(1'b1, 16 * 6);
        cmp("midrst no completion", {7'd0, rs}, 8'd0);
        send_frame(8'h5A, ^8'h5A, 1'b1, 16);
        send_bit(1'b1, 4);
        cmp("midrst d_out new", d_out, 8'h5A);
        cmp("midrst rs new", {7'd0, rs}, 8'd1);
        cmp("midrst flags", {5'd0, fe, oe, pe}, 8'd0);
        pulse_rd();
    endtask

    task automatic test_en_gating();
        gate = 1'b1;
        send_bit(1'b1, 10);
        send_frame(8'hC3, ^8'hC3, 1'b1, 32);
        send_bit(1'b1, 8);
        gate = 1'b0;
        en_rx = 1'b1;
        cmp("gated d_out", d_out, 8'hC3);
        cmp("gated rs", {7'd0, rs}, 8'd1);
        cmp("gated fe", {7'd0, fe}, 8'd0);
        pulse_rd();
        send_bit(1'b1, 16);
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b1, 16);
        send_bit(1'b1, 4);
        cmp("parity ok d_out", d_out, 8'h07);
        cmp("parity ok pe", {7'd0, pe}, 8'd0);
        pulse_rd();
        send_bit(1'b1, 16);
        send_frame(8'h07, 1'b0, 1'b1, 16);
        send_bit(1'b1, 4);
        cmp("parity bad pe", {7'd0, pe}, 8'd1);
        cmp("parity bad rs", {7'd0, rs}, 8'd1);
        pulse_rd();
        cmp("parity pe after rd", {7'd0, pe}, 8'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_rst_mid_frame();
        test_en_gating();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
